// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO controllers: default sizes, the
// write-side FSM encoding and the pointer width helper.
package fifo_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_DW   = 16;
  localparam int DEF_AW   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wr_state_t;

  // Pointers carry one wrap bit above the address so full/empty can be told apart.
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after `last`,
// searching upward with wrap-around.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic            valid
);

  always_comb begin
    int idx;
    win   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side FIFO controller: round-robin arbitration with bounded bursts
// over the single write port, owning the binary write pointer.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DW        = DEF_DW,
  parameter int AW        = DEF_AW,
  parameter int MAX_BURST = 4
) (
  input  logic                     w_clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       data,
  output logic [NREQ-1:0]          gnt,
  input  logic                     full,
  output logic                     w_en,
  output logic [DW-1:0]            D_in,
  output logic [AW:0]              b_wptr,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);

  localparam int OW = $clog2(NREQ);
  localparam int PW = ptr_width(AW);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);
  localparam logic [OW-1:0] LAST_RST = OW'(NREQ - 1);

  wr_state_t       state_reg, state_next;
  logic [OW-1:0]   last_reg, last_next;
  logic [OW-1:0]   owner_reg, owner_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [PW-1:0]   ptr_reg, ptr_next;

  logic            hold;
  logic [OW-1:0]   arb_last;
  logic [NREQ-1:0] win_oh;
  logic            win_valid;
  logic [OW-1:0]   win_idx;

  // A burst whose owner dropped req hands over in the same cycle, so the
  // search starts after the owner instead of after last.
  assign hold     = (state_reg == ST_BURST) && req[owner_reg];
  assign arb_last = (state_reg == ST_BURST) ? owner_reg : last_reg;

  rr_pick #(
    .NREQ (NREQ),
    .LW   (OW)
  ) u_pick (
    .req   (req),
    .last  (arb_last),
    .win   (win_oh),
    .valid (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) win_idx = OW'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    gnt        = '0;

    if (!rst && !full) begin
      if (hold)           gnt[owner_reg] = 1'b1;
      else if (win_valid) gnt = win_oh;
    end

    if (hold) begin
      if (!full) begin
        ptr_next = ptr_reg + 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg + 1'b1 == CNT_MAX) begin
          state_next = ST_IDLE;
          last_next  = owner_reg;
        end
      end
    end else begin
      if (state_reg == ST_BURST) begin
        state_next = ST_IDLE;
        last_next  = owner_reg;
      end
      if (!full && win_valid) begin
        ptr_next   = ptr_reg + 1'b1;
        owner_next = win_idx;
        cnt_next   = CW'(1);
        if (MAX_BURST > 1) begin
          state_next = ST_BURST;
        end else begin
          state_next = ST_IDLE;
          last_next  = win_idx;
        end
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      last_reg  <= LAST_RST;
      owner_reg <= '0;
      cnt_reg   <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    D_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) D_in = D_in | data[i*DW +: DW];
    end
  end

  assign w_en   = |gnt;
  assign b_wptr = ptr_reg;
  assign owner  = owner_reg;
  assign busy   = (state_reg == ST_BURST);

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side controller for the async FIFO: shares the single FIFO write port among NREQ requesters using round-robin arbitration with bounded bursts. It drives the FIFO's w_en and D_in, and owns the binary write pointer b_wptr, which it presents to the FIFO for gray conversion and synchronization. It lives entirely in the w_clk domain and gates every write on the FIFO's full flag.

## Interface
Parameters:
- NREQ, 4: number of requesters (≥2).
- DW, 16: data width.
- AW, 3: FIFO address width (depth 2^AW); the pointer carries one extra wrap bit.
- MAX_BURST, 4: maximum consecutive writes per grant (≥1).

Ports:
- w_clk  in  1  write-domain clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester write request; data must be held valid while high.
- data  in  NREQ*DW  requester data, packed; requester i occupies [i*DW +: DW].
- gnt  out  NREQ  one-hot accept; the write of data[i] occurs at the edge where gnt[i]=1.
- full  in  1  FIFO full flag, already synchronized to w_clk.
- w_en  out  1  FIFO write enable; equals |gnt.
- D_in  out  DW  FIFO write data; equals the granted requester's data, otherwise 0.
- b_wptr  out  AW+1  binary write pointer (address plus wrap bit).
- owner  out  clog2(NREQ)  index of the current burst owner.
- busy  out  1  high while in BURST.

## Operation
- Registered state:
  - FSM: IDLE or BURST.
  - last: the most recently served index; reset value NREQ-1, so requester 0 wins first.
  - owner.
  - cnt: writes completed in the current burst.
  - b_wptr.
- gnt, w_en and D_in are combinational from req, full and the registered state. There is no registered grant.
- full=1 forces gnt=0 in any state. b_wptr, cnt and the FSM state hold, so a burst stalls and does not abort.
- IDLE, !full, any req:
  - Winner: the first i with req[i]=1, searching (last+1) mod NREQ upward with wrap.
  - Assert gnt[winner].
  - At the edge: b_wptr+1, owner=winner, cnt=1.
  - If MAX_BURST>1, go to BURST; otherwise stay in IDLE with last=winner.
- BURST with req[owner]=1 and !full:
  - Assert gnt[owner], cnt+1.
  - When cnt reaches MAX_BURST: go to IDLE, last=owner.
- BURST with req[owner]=0: the burst ends in the same cycle.
  - last is treated as owner and the IDLE arbitration runs this cycle (no idle bubble).
  - The next state follows the IDLE rules.
- b_wptr increments by 1 per write, modulo 2^(AW+1), so it wraps from 2^(AW+1)-1 to 0.
- The block never writes while full=1. Overflow protection depends only on full being correct at the edge.
- rst, including mid-burst:
  - FSM to IDLE; b_wptr=0, cnt=0, owner=0, last=NREQ-1.
  - gnt=0, w_en=0, D_in=0 during reset.
  - No write occurs in a reset cycle.

## Timing
- Zero-cycle accept: req high with the FIFO not full gives gnt in the same cycle; the data is captured at that rising edge.
- Requester rule:
  - Data is consumed at every edge where gnt[i]=1.
  - A requester with more words updates data after each such edge and keeps req high.
  - It drops req after the edge of its last word.
- Sustained throughput is 1 write per w_clk while not full.
- Worst-case wait for a requester with req held is (NREQ-1)*MAX_BURST writes, excluding full stalls.
- b_wptr, owner and busy change only at w_clk edges.

## Structure
- Shared package fifo_pkg, which also serves the read-side controller:
  - Default DW, AW, NREQ.
  - FSM state encoding (ST_IDLE, ST_BURST).
  - Pointer width function AW+1.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req vector, last index.
  - Outputs: one-hot winner and valid.
- The top level holds the FSM, counters, pointer and data mux.

## Test plan
- Reset: assert rst for 2 cycles mid-burst (req=4'b0001) → w_en=0, gnt=0, b_wptr=0; after release, requester 0 is granted first.
- Single requester, MAX_BURST=4: req[2] held with data 5,6,7,8 → four consecutive writes, b_wptr 0→4, busy high for the burst, then IDLE with last=2.
- Round-robin fairness: req=4'b1111 held, MAX_BURST=1 → grant order 0,1,2,3,0,…, one write per cycle.
- Burst cap: req[0] and req[1] held, MAX_BURST=4 → 4 writes from 0, then 4 from 1, alternating.
- Full stall:
  - Raise full after 2 writes of a burst, hold it 3 cycles → no w_en while full; b_wptr holds at 2.
  - After full drops, the burst resumes with the same owner and completes 2 more writes.
- Early release and wrap:
  - Owner drops req mid-burst while req[3]=1 → gnt[3] in the same cycle.
  - 16 writes total → b_wptr wraps 15→0 (AW=3).
